// File: rtl/df_ctrl_pkg.sv
// Shared types for the dataflow region controller.
// Holds the one-hot FSM encoding, the in-flight counter width and the region ap_ctrl group.
package df_ctrl_pkg;

    localparam int INFL_W = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd1,
        S_ACTIVE = 3'd2,
        S_FULL   = 3'd4
    } state_t;

    typedef struct packed {
        logic start;
        logic ready;
        logic done;
        logic cont;
        logic idle;
    } ap_ctrl_t;

endpackage

// File: rtl/df_sticky_sync.sv
// Sticky-bit bank: collects per-process events until every bit is seen, then clears.
// all_set includes the current cycle's set bits, so the full group is reported with zero latency.
module df_sticky_sync #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] set,
    input  logic         clear,
    output logic [N-1:0] acc,
    output logic         all_set
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else begin
            acc <= acc | set;
        end
    end

    assign all_set = &(acc | set);

endmodule

// File: rtl/dataflow_region_ctrl.sv
// Region-level ap_ctrl_chain sequencer: broadcasts start, joins ready/done,
// bounds in-flight iterations and counts retired iterations.
module dataflow_region_ctrl
    import df_ctrl_pkg::*;
#(
    parameter int NPROC        = 3,
    parameter int MAX_INFLIGHT = 2,
    parameter int ITER_W       = 32
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_ready,
    output logic              ap_done,
    input  logic              ap_continue,
    output logic              ap_idle,
    output logic [NPROC-1:0]  proc_start,
    input  logic [NPROC-1:0]  proc_ready,
    input  logic [NPROC-1:0]  proc_done,
    output logic [NPROC-1:0]  proc_continue,
    input  logic [NPROC-1:0]  proc_idle,
    output logic [INFL_W-1:0] inflight,
    output logic [ITER_W-1:0] iter_cnt,
    output logic              err_underflow,
    output state_t            dbg_state
);

    localparam logic [INFL_W-1:0] MAX_I = INFL_W'(MAX_INFLIGHT);

    // Handshake semantics: a process accepts start on proc_start&proc_ready (start acts as valid,
    // ready as ready); the region retires an iteration on ap_done&ap_continue (done as valid,
    // continue as ready). Neither side may drop its valid before the matching ready is seen.
    ap_ctrl_t          region;
    logic [INFL_W-1:0] inflight_q, inflight_d;
    state_t            state_q, state_d;
    logic [NPROC-1:0]  start_acc, start_set, done_acc;
    logic              can_start, real_start, all_started, all_done_raw;
    logic              accept, retire, underflow;

    assign region.start = ap_start;
    assign region.cont  = ap_continue;
    assign region.idle  = (&proc_idle) & (inflight_q == '0) & ~region.start;

    assign can_start  = (inflight_q < MAX_I);
    assign real_start = region.start & can_start & ap_rst_n;
    assign proc_start = {NPROC{real_start}} & ~start_acc;
    assign start_set  = proc_start & proc_ready;

    df_sticky_sync #(.N(NPROC)) u_start_sync (
        .clk     (ap_clk),
        .rst_n   (ap_rst_n),
        .set     (start_set),
        .clear   (all_started),
        .acc     (start_acc),
        .all_set (all_started)
    );

    df_sticky_sync #(.N(NPROC)) u_done_sync (
        .clk     (ap_clk),
        .rst_n   (ap_rst_n),
        .set     (proc_done),
        .clear   (retire),
        .acc     (done_acc),
        .all_set (all_done_raw)
    );

    // Gated by reset so nothing is released downstream while the region is held in reset.
    assign region.ready  = all_started & ap_rst_n;
    assign region.done   = all_done_raw & ap_rst_n;
    assign accept        = region.ready;
    assign retire        = region.done & region.cont;
    assign proc_continue = {NPROC{retire}};
    assign underflow     = retire & ~accept & (inflight_q == '0);

    always_comb begin
        inflight_d = inflight_q;
        state_d    = S_ACTIVE;
        if (accept && !retire) begin
            inflight_d = inflight_q + INFL_W'(1);
        end else if (retire && !accept && inflight_q != '0) begin
            inflight_d = inflight_q - INFL_W'(1);
        end
        if (inflight_d == '0) begin
            state_d = S_IDLE;
        end else if (inflight_d >= MAX_I) begin
            state_d = S_FULL;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            inflight_q    <= '0;
            state_q       <= S_IDLE;
            iter_cnt      <= '0;
            err_underflow <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            state_q    <= state_d;
            if (retire) begin
                iter_cnt <= iter_cnt + ITER_W'(1);
            end
            if (underflow) begin
                err_underflow <= 1'b1;
            end
        end
    end

    assign ap_ready  = region.ready;
    assign ap_done   = region.done;
    assign ap_idle   = region.idle;
    assign inflight  = inflight_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dataflow_region_ctrl.sv
// Bench for dataflow_region_ctrl: directed scenarios plus random traffic checked
// against an iteration-level reference model.
module tb_dataflow_region_ctrl;
    import df_ctrl_pkg::*;

    localparam int NPROC  = 3;
    localparam int MAXI   = 2;
    localparam int ITER_W = 32;

    logic              ap_clk = 1'b0;
    logic              ap_rst_n;
    logic              ap_start;
    logic              ap_ready;
    logic              ap_done;
    logic              ap_continue;
    logic              ap_idle;
    logic [NPROC-1:0]  proc_start;
    logic [NPROC-1:0]  proc_ready;
    logic [NPROC-1:0]  proc_done;
    logic [NPROC-1:0]  proc_continue;
    logic [NPROC-1:0]  proc_idle;
    logic [3:0]        inflight;
    logic [ITER_W-1:0] iter_cnt;
    logic              err_underflow;
    state_t            dbg_state;

    int checks = 0;
    int passed = 0;

    // Reference model: iterations in flight, retired count, and which processes
    // have already taken the current start / reported the current done.
    int          m_infl, n_infl;
    int unsigned m_iter, n_iter;
    bit          m_err, n_err;
    bit          m_started [NPROC];
    bit          n_started [NPROC];
    bit          m_dseen   [NPROC];
    bit          n_dseen   [NPROC];

    dataflow_region_ctrl #(
        .NPROC        (NPROC),
        .MAX_INFLIGHT (MAXI),
        .ITER_W       (ITER_W)
    ) dut (
        .ap_clk        (ap_clk),
        .ap_rst_n      (ap_rst_n),
        .ap_start      (ap_start),
        .ap_ready      (ap_ready),
        .ap_done       (ap_done),
        .ap_continue   (ap_continue),
        .ap_idle       (ap_idle),
        .proc_start    (proc_start),
        .proc_ready    (proc_ready),
        .proc_done     (proc_done),
        .proc_continue (proc_continue),
        .proc_idle     (proc_idle),
        .inflight      (inflight),
        .iter_cnt      (iter_cnt),
        .err_underflow (err_underflow),
        .dbg_state     (dbg_state)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_infl = 0; m_iter = 0; m_err = 1'b0;
        for (int i = 0; i < NPROC; i++) begin
            m_started[i] = 1'b0;
            m_dseen[i]   = 1'b0;
        end
    endtask

    function automatic logic [31:0] exp_state(input int infl);
        if (infl == 0) return 32'd1;
        if (infl >= MAXI) return 32'd4;
        return 32'd2;
    endfunction

    // Drive one cycle of inputs, check every output against the model, prepare the model's next state.
    task automatic step(input logic s, input logic [NPROC-1:0] rdy, input logic [NPROC-1:0] dn,
                        input logic c, input logic [NPROC-1:0] idl);
        logic             rs, all_acc, all_dn, ret;
        logic [NPROC-1:0] eps;
        ap_start = s; proc_ready = rdy; proc_done = dn; ap_continue = c; proc_idle = idl;
        #1;
        rs      = s && (m_infl < MAXI);
        all_acc = 1'b1;
        all_dn  = 1'b1;
        for (int i = 0; i < NPROC; i++) begin
            eps[i] = rs && !m_started[i];
            if (!(m_started[i] || (eps[i] && rdy[i]))) all_acc = 1'b0;
            if (!(m_dseen[i] || dn[i])) all_dn = 1'b0;
        end
        ret = all_dn && c;
        chk("proc_start",    32'(proc_start),    32'(eps));
        chk("ap_ready",      32'(ap_ready),      32'(all_acc));
        chk("ap_done",       32'(ap_done),       32'(all_dn));
        chk("proc_continue", 32'(proc_continue), ret ? 32'h7 : 32'h0);
        chk("ap_idle",       32'(ap_idle),       32'((&idl) && m_infl == 0 && !s));
        chk("inflight",      32'(inflight),      32'(m_infl));
        chk("iter_cnt",      iter_cnt,           m_iter);
        chk("err_underflow", 32'(err_underflow), 32'(m_err));
        chk("state",         32'(dbg_state),     exp_state(m_infl));
        n_infl = m_infl; n_iter = m_iter; n_err = m_err;
        for (int i = 0; i < NPROC; i++) begin
            n_started[i] = all_acc ? 1'b0 : (m_started[i] | (eps[i] & rdy[i]));
            n_dseen[i]   = ret ? 1'b0 : (m_dseen[i] | dn[i]);
        end
        if (all_acc && !ret) begin
            n_infl = m_infl + 1;
        end else if (ret && !all_acc) begin
            if (m_infl == 0) n_err = 1'b1;
            else n_infl = m_infl - 1;
        end
        if (ret) n_iter = m_iter + 1;
    endtask

    task automatic tick();
        @(posedge ap_clk);
        m_infl = n_infl; m_iter = n_iter; m_err = n_err;
        for (int i = 0; i < NPROC; i++) begin
            m_started[i] = n_started[i];
            m_dseen[i]   = n_dseen[i];
        end
        #1;
    endtask

    initial begin
        int guard;
        // Reset: outputs forced low even with a start request pending
        ap_rst_n = 1'b0; ap_start = 1'b1; proc_ready = 3'b111; proc_done = 3'b111;
        ap_continue = 1'b1; proc_idle = 3'b111;
        model_reset();
        repeat (2) @(posedge ap_clk);
        #1;
        chk("rst_proc_start", 32'(proc_start), 32'h0);
        chk("rst_ap_ready",   32'(ap_ready),   32'h0);
        chk("rst_ap_done",    32'(ap_done),    32'h0);
        chk("rst_continue",   32'(proc_continue), 32'h0);
        chk("rst_inflight",   32'(inflight),   32'h0);
        chk("rst_iter",       iter_cnt,        32'h0);
        ap_start = 1'b0; proc_done = 3'b000; ap_continue = 1'b0;
        @(negedge ap_clk) ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;

        // Zero-latency ready when every process accepts together
        step(1'b1, 3'b111, 3'b000, 1'b0, 3'b000);
        chk("t1_ap_ready", 32'(ap_ready), 32'h1);
        tick();
        step(1'b0, 3'b000, 3'b000, 1'b0, 3'b000);
        chk("t1_ps_drop",  32'(proc_start), 32'h0);
        chk("t1_inflight", 32'(inflight),   32'h1);
        tick();

        // Staggered readies
        step(1'b1, 3'b001, 3'b000, 1'b0, 3'b000); chk("t2_ps1", 32'(proc_start), 32'h7); tick();
        step(1'b1, 3'b100, 3'b000, 1'b0, 3'b000); chk("t2_ps2", 32'(proc_start), 32'h6); tick();
        step(1'b1, 3'b000, 3'b000, 1'b0, 3'b000); chk("t2_ps3", 32'(proc_start), 32'h2);
        chk("t2_rdy3", 32'(ap_ready), 32'h0); tick();
        step(1'b1, 3'b010, 3'b000, 1'b0, 3'b000); chk("t2_ps4", 32'(proc_start), 32'h2);
        chk("t2_rdy4", 32'(ap_ready), 32'h1); tick();

        // Full: start held but blocked
        step(1'b1, 3'b111, 3'b000, 1'b0, 3'b000);
        chk("t3_ps_full",  32'(proc_start), 32'h0);
        chk("t3_rdy_full", 32'(ap_ready),   32'h0);
        chk("t3_infl",     32'(inflight),   32'h2);
        chk("t3_state",    32'(dbg_state),  32'h4);
        tick();

        // Done bits over three cycles, continue held off
        step(1'b1, 3'b000, 3'b001, 1'b0, 3'b000); chk("t4_done1", 32'(ap_done), 32'h0); tick();
        step(1'b1, 3'b000, 3'b011, 1'b0, 3'b000); chk("t4_done2", 32'(ap_done), 32'h0); tick();
        step(1'b1, 3'b000, 3'b111, 1'b0, 3'b000); chk("t4_done3", 32'(ap_done), 32'h1);
        chk("t4_cont_hold", 32'(proc_continue), 32'h0); tick();
        step(1'b1, 3'b000, 3'b111, 1'b1, 3'b000); chk("t4_cont", 32'(proc_continue), 32'h7); tick();
        step(1'b1, 3'b000, 3'b000, 1'b0, 3'b000);
        chk("t4_released", 32'(proc_start),    32'h7);
        chk("t4_iter",     iter_cnt,           32'h1);
        chk("t4_infl",     32'(inflight),      32'h1);
        chk("t4_cont_off", 32'(proc_continue), 32'h0);
        tick();

        // Accept and retire together at inflight=1
        step(1'b1, 3'b111, 3'b111, 1'b1, 3'b000);
        chk("t5_both_rdy", 32'(ap_ready), 32'h1);
        tick();
        step(1'b0, 3'b000, 3'b000, 1'b0, 3'b000);
        chk("t5_infl_same", 32'(inflight), 32'h1);
        chk("t5_iter",      iter_cnt,      32'h2);
        tick();

        // Random traffic; done only while something is in flight
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 (m_infl > 0) ? 3'($urandom_range(0, 7)) : 3'b000,
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            tick();
        end

        // Drain, then retire with nothing in flight
        guard = 0;
        while (m_infl > 0 && guard < 20) begin
            step(1'b0, 3'b000, 3'b111, 1'b1, 3'b111);
            tick();
            guard++;
        end
        step(1'b0, 3'b000, 3'b000, 1'b0, 3'b111);
        chk("t5_drained", 32'(inflight), 32'h0);
        tick();
        step(1'b0, 3'b000, 3'b111, 1'b1, 3'b111);
        tick();
        step(1'b0, 3'b000, 3'b000, 1'b0, 3'b111);
        chk("t5_err",       32'(err_underflow), 32'h1);
        chk("t5_infl_zero", 32'(inflight),      32'h0);
        tick();

        // Asynchronous reset mid-iteration
        step(1'b1, 3'b000, 3'b111, 1'b0, 3'b111);
        chk("t6_done_pre", 32'(ap_done), 32'h1);
        #2 ap_rst_n = 1'b0;
        #1;
        chk("t6_ps_rst",   32'(proc_start),    32'h0);
        chk("t6_rdy_rst",  32'(ap_ready),      32'h0);
        chk("t6_done_rst", 32'(ap_done),       32'h0);
        chk("t6_cont_rst", 32'(proc_continue), 32'h0);
        model_reset();
        ap_start = 1'b0; proc_done = 3'b000;
        @(posedge ap_clk);
        @(negedge ap_clk) ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        step(1'b0, 3'b000, 3'b000, 1'b0, 3'b111);
        chk("t6_infl", 32'(inflight),      32'h0);
        chk("t6_iter", iter_cnt,           32'h0);
        chk("t6_idle", 32'(ap_idle),       32'h1);
        chk("t6_err",  32'(err_underflow), 32'h0);
        tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
